// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared state encoding and default width for period_meter
package period_meter_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

endpackage

// File: rtl/period_meter_sync_edge.sv
// rtl/period_meter_sync_edge.sv - two-flop synchronizer plus delay flop, both-polarity edge detect
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic edge_det
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= sig_in;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign edge_det = sync_q ^ dly_q;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures half-period and period of a slow signal in clk ticks
module period_meter
  import period_meter_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_TICKS = 32'd100_000_000,
  parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] half_period,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic edge_det;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] prev_half_q, prev_half_d;
  logic [CNT_W-1:0] half_d, period_d;
  logic             have_first_q, have_first_d;
  logic             valid_d, timeout_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0]   sum_full;
  logic [CNT_W-1:0] sum_sat;

  sync_edge u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .edge_det (edge_det)
  );

  assign cnt_inc  = cnt_q + CNT_ONE;
  assign sum_full = {1'b0, prev_half_q} + {1'b0, cnt_inc};
  assign sum_sat  = sum_full[CNT_W] ? '1 : sum_full[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      half_period  <= '0;
      period       <= '0;
      prev_half_q  <= '0;
      have_first_q <= 1'b0;
      valid        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      half_period  <= half_d;
      period       <= period_d;
      prev_half_q  <= prev_half_d;
      have_first_q <= have_first_d;
      valid        <= valid_d;
      timeout      <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_period;
    period_d     = period;
    prev_half_d  = prev_half_q;
    have_first_d = have_first_q;
    valid_d      = 1'b0;

    if (!enable) begin
      state_d      = IDLE;
      cnt_d        = '0;
      have_first_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (edge_det) begin
            state_d      = MEASURE;
            have_first_d = 1'b0;
          end
        end
        MEASURE: begin
          // an edge on the last count still counts as a capture, not a timeout
          if (edge_det) begin
            half_d       = cnt_inc;
            prev_half_d  = cnt_inc;
            cnt_d        = '0;
            have_first_d = 1'b1;
            if (have_first_q) begin
              period_d = sum_sat;
              valid_d  = 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_d = TIMEOUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        TIMEOUT: begin
          cnt_d = '0;
          if (edge_det) begin
            state_d      = MEASURE;
            have_first_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    timeout_d = (state_d == TIMEOUT);
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed self-checking bench for period_meter
`timescale 1ns/1ps
module tb_period_meter;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        sig_in;
  logic [31:0] half_period;
  logic [31:0] period;
  logic        valid;
  logic        timeout;

  int n_cmp = 0;
  int n_mis = 0;

  bit run    = 1'b0;
  int hi_len = 10;
  int lo_len = 10;
  int ph_cnt = 0;

  int k;
  int hits;
  int vcnt;

  period_meter #(
    .TIMEOUT_TICKS (32'd50),
    .CNT_W         (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sig_in      (sig_in),
    .half_period (half_period),
    .period      (period),
    .valid       (valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slow toggler: sig_in flips on the first tick after run is set, then every hi_len/lo_len ticks
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (run) begin
        if (ph_cnt == 0) begin
          sig_in = ~sig_in;
          ph_cnt = sig_in ? hi_len : lo_len;
        end
        ph_cnt = ph_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    run    = 1'b0;
    ph_cnt = 0;
    sig_in = 1'b0;
    enable = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output int cyc, output int to_hits);
    cyc     = -1;
    to_hits = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (timeout) to_hits++;
      if (valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_timeout(input logic level, input int max, output int cyc, output int v_hits);
    cyc    = -1;
    v_hits = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (valid) v_hits++;
      if (timeout == level) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;

    // reset state
    do_reset();
    check("rst_half", half_period, 32'd0);
    check("rst_period", period, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);

    // symmetric 10/10 toggling
    hi_len = 10; lo_len = 10;
    run = 1'b1;
    wait_valid(100, k, hits);
    check("sym_first_valid_cyc", k, 32'd24);
    check("sym_half", half_period, 32'd10);
    check("sym_period", period, 32'd20);
    @(negedge clk);
    check("sym_valid_pulse", {31'd0, valid}, 32'd0);
    vcnt = 0;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    check("sym_valid_count", vcnt, 32'd10);

    // asymmetric 7 high / 13 low
    do_reset();
    hi_len = 7; lo_len = 13;
    run = 1'b1;
    wait_valid(100, k, hits);
    check("asym_first_cyc", k, 32'd24);
    check("asym_half_a", half_period, 32'd13);
    check("asym_period_a", period, 32'd20);
    wait_valid(40, k, hits);
    check("asym_gap_b", k, 32'd7);
    check("asym_half_b", half_period, 32'd7);
    check("asym_period_b", period, 32'd20);
    wait_valid(40, k, hits);
    check("asym_gap_c", k, 32'd13);
    check("asym_half_c", half_period, 32'd13);

    // loss of signal and recovery
    do_reset();
    hi_len = 10; lo_len = 10;
    run = 1'b1;
    wait_valid(100, k, hits);
    check("to_pre_valid_cyc", k, 32'd24);
    run = 1'b0;
    wait_timeout(1'b1, 100, k, hits);
    check("to_rise_cyc", k, 32'd50);
    check("to_no_valid", hits, 32'd0);
    check("to_half_held", half_period, 32'd10);
    check("to_period_held", period, 32'd20);
    repeat (10) @(negedge clk);
    check("to_level_held", {31'd0, timeout}, 32'd1);
    ph_cnt = 0;
    run = 1'b1;
    wait_timeout(1'b0, 50, k, hits);
    check("to_fall_cyc", k, 32'd4);
    wait_valid(100, k, hits);
    check("to_resume_valid_cyc", k, 32'd20);
    check("to_resume_period", period, 32'd20);

    // edge landing exactly on the last count
    do_reset();
    hi_len = 50; lo_len = 50;
    run = 1'b1;
    wait_valid(200, k, hits);
    check("edge_last_cyc", k, 32'd104);
    check("edge_last_half", half_period, 32'd50);
    check("edge_last_period", period, 32'd100);
    check("edge_last_no_timeout", hits, 32'd0);

    // async reset mid-period, then enable dropped during MEASURE
    do_reset();
    hi_len = 10; lo_len = 10;
    run = 1'b1;
    wait_valid(100, k, hits);
    run = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_half", half_period, 32'd0);
    check("arst_period", period, 32'd0);
    check("arst_flags", {30'd0, valid, timeout}, 32'd0);
    @(negedge clk);
    sig_in = 1'b1;
    @(negedge clk);
    rst_n  = 1'b1;
    ph_cnt = 9;
    run    = 1'b1;
    repeat (15) @(negedge clk);
    check("arst_restart_half", half_period, 32'd10);
    enable = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid || timeout) vcnt++;
    end
    check("dis_flags_low", vcnt, 32'd0);
    check("dis_half_held", half_period, 32'd10);
    enable = 1'b1;
    wait_valid(100, k, hits);
    check("dis_first_valid_cyc", k, 32'd23);
    check("dis_period", period, 32'd20);

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 32'd100_000_000, SHALL be the number of clk cycles without an input edge that declares loss of signal.
REQ-002 Parameter CNT_W, default 32, SHALL be the width of all tick counters and measurement outputs.
REQ-003 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 enable  input  1  SHALL be synchronous measurement enable; low forces IDLE.
REQ-006 sig_in  input  1  SHALL be the slow toggling signal, asynchronous to clk.
REQ-007 half_period  output  CNT_W  SHALL be the clk-cycle count between the last two edges of sig_in.
REQ-008 period  output  CNT_W  SHALL be the sum of the last two half_period captures.
REQ-009 valid  output  1  SHALL be a one-cycle pulse each time period updates.
REQ-010 timeout  output  1  SHALL be a level that is high while in TIMEOUT.

Function
REQ-011 sig_in SHALL pass a 2-flop synchronizer, then a delay flop; edge = sync_out XOR delayed (both polarities).
REQ-012 Latency from a sig_in change to the edge-detect cycle SHALL be 3 clk cycles (±1 for metastability resolution).
REQ-013 FSM states SHALL be IDLE, MEASURE, TIMEOUT.
REQ-014 IDLE: cnt held at 0; on edge with enable=1 -> MEASURE, cnt <= 0, no capture.
REQ-015 MEASURE, non-edge cycle: cnt <= cnt + 1.
REQ-016 MEASURE, edge cycle: half_period <= cnt + 1, prev_half <= cnt + 1, cnt <= 0; edges N cycles apart SHALL therefore yield half_period = N.
REQ-017 First capture after entering MEASURE SHALL update half_period only; from the second capture onward each edge SHALL set period <= prev_half + (cnt + 1) and pulse valid in the same cycle period updates.
REQ-018 MEASURE with cnt == TIMEOUT_TICKS-1 and no edge SHALL -> TIMEOUT; timeout high from the next cycle.
REQ-019 Edge and timeout condition in the same cycle: edge SHALL win (capture, stay MEASURE).
REQ-020 TIMEOUT: on edge -> MEASURE, timeout low next cycle, cnt <= 0, capture count restarted (next two captures required before valid).
REQ-021 half_period and period SHALL hold their last values through TIMEOUT and IDLE.
REQ-022 enable=0 in any state SHALL -> IDLE next cycle, timeout <= 0, valid <= 0, capture count cleared; enable has priority over edge.
REQ-023 cnt SHALL never wrap: it is bounded by TIMEOUT_TICKS-1; the sum in REQ-017 SHALL saturate at all-ones of CNT_W.
REQ-024 The synchronizer SHALL run in every state so an edge is never lost or spuriously produced on re-enable.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, cnt=0, half_period=0, period=0, prev_half=0, valid=0, timeout=0, all synchronizer/delay flops=0.
REQ-026 Reset asserted mid-measurement SHALL discard partial counts; after release, a high sig_in SHALL produce one edge (0->1 seen by the synchronizer) treated as the IDLE start edge.

Structure
REQ-027 Package period_meter_pkg SHALL hold the state enum (IDLE, MEASURE, TIMEOUT) and the default CNT_W constant.
REQ-028 Sub-module sync_edge (2-flop synchronizer, delay flop, edge output, async active-low reset) SHALL be instantiated once.
REQ-029 Counter, capture registers, and FSM SHALL reside in period_meter.

Verification
REQ-030 sig_in driven by the team slow clock divider with TICKS=9 on the same clk, enable=1 -> half_period=10, period=20, valid pulses every 10 cycles from the second capture.
REQ-031 Asymmetric sig_in, high 7 cycles / low 13 cycles -> half_period alternates 7/13, period=20 on every valid.
REQ-032 TIMEOUT_TICKS=50, sig_in frozen after steady toggling -> timeout rises 51 cycles after last edge-detect, half_period/period unchanged; resume toggling -> timeout drops, first valid only after two captures.
REQ-033 Edge arriving exactly when cnt == TIMEOUT_TICKS-1 -> half_period=TIMEOUT_TICKS, no timeout.
REQ-034 rst_n pulsed low mid-period, then enable toggled low for 5 cycles during MEASURE -> all outputs 0 asynchronously; after enable return, state IDLE, no valid until two captures.
